// File: rtl/bf16_to_int_converter.sv
// bfloat16 -> signed INT_W-bit integer converter; normalises with one shift per cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even instead of truncation toward zero.
module bf16_to_int_converter #(
  parameter int INT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      a,
  output logic             ready,
  output logic             done,
  output logic [INT_W-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, EXTRACT, SHIFT, SIGN} state_t;

  localparam logic [INT_W-1:0] POS_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] NEG_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [9:0] K_TOP  = 10'(INT_W - 1);

  state_t           state_r;
  logic             sign_r;
  logic [7:0]       exp_r;
  logic [6:0]       man_r;
  logic [INT_W-1:0] mag_r;
  logic [4:0]       cnt_r;
  logic             shl_r;
  logic             special_r;
  logic             ovf_r;
`ifdef ROUND_NEAREST_EN
  logic             guard_r;
  logic             sticky_r;

  function automatic logic [INT_W-1:0] round_even(input logic [INT_W-1:0] mag,
                                                  input logic guard, input logic sticky);
    logic inc;
    inc = guard & (sticky | mag[0]);
    return mag + {{(INT_W-1){1'b0}}, inc};
  endfunction
`endif

  logic signed [9:0] k_s;
  logic              is_nan_s;
  logic              is_small_s;
  logic              is_sat_s;
  logic              is_min_s;
  logic              shl_s;
  logic [4:0]        n_s;
  logic [INT_W-1:0]  fin_s;

  // Classify the captured operand and derive shift direction/count for the normal class.
  always_comb begin
    k_s        = $signed({2'b00, exp_r}) - 10'sd127;
    is_nan_s   = (exp_r == 8'hFF) && (man_r != 7'd0);
    is_small_s = (exp_r < 8'd127);
    is_sat_s   = !is_nan_s && !is_small_s &&
                 ((k_s > K_TOP) || ((k_s == K_TOP) && (!sign_r || (man_r != 7'd0))));
    is_min_s   = !is_nan_s && !is_small_s && !is_sat_s && (k_s == K_TOP);
    if (k_s < 10'sd7) begin
      shl_s = 1'b0;
      n_s   = 5'(10'sd7 - k_s);
    end else begin
      shl_s = 1'b1;
      n_s   = 5'(k_s - 10'sd7);
    end
  end

  // Final unsigned magnitude before sign application.
  always_comb begin
`ifdef ROUND_NEAREST_EN
    if (special_r) begin
      fin_s = mag_r;
    end else begin
      fin_s = round_even(mag_r, guard_r, sticky_r);
    end
`else
    fin_s = mag_r;
`endif
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      sign_r    <= 1'b0;
      exp_r     <= 8'd0;
      man_r     <= 7'd0;
      mag_r     <= '0;
      cnt_r     <= 5'd0;
      shl_r     <= 1'b0;
      special_r <= 1'b0;
      ovf_r     <= 1'b0;
`ifdef ROUND_NEAREST_EN
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
`endif
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_r  <= a[15];
            exp_r   <= a[14:7];
            man_r   <= a[6:0];
            ready   <= 1'b0;
            state_r <= EXTRACT;
          end else begin
            ready <= 1'b1;
          end
        end
        EXTRACT: begin
          cnt_r     <= 5'd0;
          shl_r     <= 1'b0;
          special_r <= 1'b1;
          ovf_r     <= 1'b0;
`ifdef ROUND_NEAREST_EN
          guard_r   <= 1'b0;
          sticky_r  <= 1'b0;
`endif
          state_r   <= SIGN;
          if (is_nan_s) begin
            mag_r <= '0;
            ovf_r <= 1'b1;
          end else if (is_small_s) begin
            mag_r <= '0;
          end else if (is_sat_s) begin
            mag_r <= sign_r ? NEG_MIN : POS_MAX;
            ovf_r <= 1'b1;
          end else if (is_min_s) begin
            mag_r <= NEG_MIN;
          end else begin
            mag_r     <= {{(INT_W-8){1'b0}}, 1'b1, man_r};
            special_r <= 1'b0;
            cnt_r     <= n_s;
            shl_r     <= shl_s;
            if (n_s != 5'd0) begin
              state_r <= SHIFT;
            end else begin
              state_r <= SIGN;
            end
          end
        end
        SHIFT: begin
          if (shl_r) begin
            mag_r <= mag_r << 1;
          end else begin
            mag_r <= mag_r >> 1;
`ifdef ROUND_NEAREST_EN
            guard_r  <= mag_r[0];
            sticky_r <= sticky_r | guard_r;
`endif
          end
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            state_r <= SIGN;
          end else begin
            state_r <= SHIFT;
          end
        end
        SIGN: begin
          result   <= (!special_r && sign_r) ? (~fin_s + {{(INT_W-1){1'b0}}, 1'b1}) : fin_s;
          overflow <= ovf_r;
          done     <= 1'b1;
          ready    <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_to_int_converter.sv
// Directed bench for bf16_to_int_converter (INT_W=16) checked every cycle against a real-arithmetic model.
module tb_bf16_to_int_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  bf16_to_int_converter #(.INT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a),
    .ready(ready), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;
  logic [15:0] held_res = 16'd0;
  logic        held_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at edge %0d", nm, act, exp, cyc);
    end
  endtask

  // Value-level model: real-valued magnitude, then saturate / truncate / round.
  function automatic void model(input logic [15:0] x, output logic [15:0] r,
                                output logic ov, output int lat);
    int  e, m, iv;
    bit  s;
    real mag, v, fl, fr;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    s = x[15];
    lat = 3;
    ov  = 1'b0;
    r   = 16'd0;
    if (e == 255 && m != 0) begin
      ov = 1'b1;
    end else if (e == 255) begin
      ov = 1'b1;
      r  = s ? 16'h8000 : 16'h7FFF;
    end else if (e < 127) begin
      r = 16'd0;
    end else begin
      mag = (128.0 + real'(m)) * (2.0 ** real'(e - 134));
      v   = s ? -mag : mag;
      if (v > 32767.0) begin
        r = 16'h7FFF; ov = 1'b1;
      end else if (v < -32768.0) begin
        r = 16'h8000; ov = 1'b1;
      end else if (v == -32768.0) begin
        r = 16'h8000;
      end else begin
        fl = $floor(mag);
        iv = $rtoi(fl);
`ifdef ROUND_NEAREST_EN
        fr = mag - fl;
        if (fr > 0.5 || (fr == 0.5 && (iv % 2) == 1)) iv = iv + 1;
`else
        fr = 0.0;
`endif
        r   = 16'(s ? -iv : iv);
        lat = ((e > 134) ? (e - 134) : (134 - e)) + 3;
      end
    end
  endfunction

  // Edge monitor: counts edges, flushes on reset, records accepted requests.
  always @(posedge clock) begin
    exp_t        it;
    logic [15:0] r;
    logic        ov;
    int          lat;
    cyc++;
    if (reset) begin
      q.delete();
      held_res = 16'd0;
      held_ovf = 1'b0;
      armed    = 1'b1;
    end else if (armed && start && q.size() == 0) begin
      model(a, r, ov, lat);
      it.res = r;
      it.ovf = ov;
      it.due = cyc + lat - 1;
      q.push_back(it);
      n_acc++;
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clock) begin
    logic exp_done;
    if (armed) begin
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (exp_done) begin
        held_res = q[0].res;
        held_ovf = q[0].ovf;
        void'(q.pop_front());
      end
      chk("result", {16'd0, result}, {16'd0, held_res});
      chk("overflow", {31'd0, overflow}, {31'd0, held_ovf});
      chk("ready", {31'd0, ready}, {31'd0, (q.size() == 0)});
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(posedge clock); #2;
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy expected idle at edge %0d", cyc);
      q.delete();
    end
  endtask

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (n_acc < target && k < 60) begin
      @(posedge clock); #2;
      k++;
    end
    n_cmp++;
    if (n_acc < target) begin
      n_bad++;
      $display("FAIL accept_timeout: got %0d expected %0d", n_acc, target);
    end
  endtask

  task automatic run_op(input logic [15:0] x);
    a = x;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    wait_idle();
    @(posedge clock); #2;
  endtask

  task automatic pin(input logic [15:0] x, input logic [15:0] er, input logic eo, input int el);
    logic [15:0] r;
    logic        ov;
    int          lat;
    model(x, r, ov, lat);
    chk($sformatf("model_res_%h", x), {16'd0, r}, {16'd0, er});
    chk($sformatf("model_ovf_%h", x), {31'd0, ov}, {31'd0, eo});
    chk($sformatf("model_lat_%h", x), lat, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    start = 1'b0;
    a     = 16'h0000;
    pin(16'h3F80, 16'h0001, 1'b0, 10);
    pin(16'h42C8, 16'h0064, 1'b0, 4);
    pin(16'hC380, 16'hFF00, 1'b0, 4);
    pin(16'hC700, 16'h8000, 1'b0, 3);
    pin(16'h471C, 16'h7FFF, 1'b1, 3);
    pin(16'h7F80, 16'h7FFF, 1'b1, 3);
    pin(16'h7FC1, 16'h0000, 1'b1, 3);
    pin(16'h3F00, 16'h0000, 1'b0, 3);
`ifdef ROUND_NEAREST_EN
    pin(16'h4060, 16'h0004, 1'b0, 9);
    pin(16'h4020, 16'h0002, 1'b0, 9);
    pin(16'hC060, 16'hFFFC, 1'b0, 9);
`else
    pin(16'h4060, 16'h0003, 1'b0, 9);
    pin(16'h4020, 16'h0002, 1'b0, 9);
    pin(16'hC060, 16'hFFFD, 1'b0, 9);
`endif
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock); #2;

    foreach (vec[i]) run_op(vec[i]);

    // start pulsed while busy must be ignored
    a = 16'h3F80; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    a = 16'h7FC1; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    wait_idle();
    @(posedge clock); #2;

    // start held through done: second operand accepted in the done cycle
    base = n_acc;
    a = 16'h42C8; start = 1'b1;
    wait_acc(base + 1);
    a = 16'hC380;
    wait_acc(base + 2);
    start = 1'b0;
    wait_idle();
    @(posedge clock); #2;

    // reset in the middle of SHIFT
    a = 16'h3F80; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #2;
    run_op(16'h4020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [15:0] vec [12] = '{16'h3F80, 16'h42C8, 16'hC380, 16'hC700, 16'h471C, 16'h7F80,
                           16'h7FC1, 16'h3F00, 16'h4060, 16'h4020, 16'hC060, 16'hFF80};

endmodule

// File: doc/bf16_to_int_converter.md
Name: bf16_to_int_converter

Overview:
- Multi-cycle converter from a bfloat16 operand to a signed two's-complement integer.
- Decodes the format produced by the team's bfloat16 adder: sign, 8-bit exponent (bias 127), 7-bit mantissa with hidden 1.
- Sits on the adder's output side, so float results can be consumed by integer datapaths.
- Normalises iteratively, one shift per cycle, with a start/ready/done handshake.

Parameters:
- INT_W, 16: integer result width. Legal range is 9 to 32.

Ports:
- clock  input  1  rising-edge clock; the only clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  16  bfloat16 operand; captured on the accepting edge.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; result and overflow are valid with it.
- result  output  INT_W  signed integer result; held until the next done.
- overflow  output  1  out-of-range or NaN flag; held with result.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clock.
  - State goes to IDLE. result=0, overflow=0, done=0, ready=1.
  - Any conversion in flight is discarded with no done pulse.
  - Reset has priority over start.
- States: IDLE, EXTRACT, SHIFT, SIGN.
- IDLE:
  - On start=1, capture a into the internal sign, exponent and mantissa registers, then go to EXTRACT.
  - start is ignored in every other state.
- EXTRACT: compute k = e-127 and classify. Every class except Normal goes directly to SIGN with magnitude preset; n=0.
  - NaN (e=255, mantissa!=0): result 0, overflow=1.
  - Inf, or k>INT_W-1, or k=INT_W-1 with (sign=0 or mantissa!=0): saturate. +max (2^(INT_W-1)-1) if sign=0, -2^(INT_W-1) if sign=1. overflow=1.
  - Exact minimum (k=INT_W-1, sign=1, mantissa=0): result -2^(INT_W-1), overflow=0.
  - Zero, denormal, or e<127 (|a|<1): result 0, overflow=0.
  - Normal (0<=k<=INT_W-2):
    - Set mag = zero-extended {1,mantissa}.
    - n = 7-k right shifts if k<7, otherwise k-7 left shifts.
    - Go to SHIFT if n>0, else SIGN.
- SHIFT: one bit shift of mag per cycle. A down-counter tracks n; go to SIGN after the last shift.
- SIGN:
  - Negate mag if sign=1 (Normal class only). Register it to result.
  - Set done=1 for exactly one cycle. Go to IDLE.
  - Right shifts truncate toward zero.
- Latency: counting the start-sampling edge as edge 1, done is high after edge n+3.
  - Special classes always take 3 edges.
  - ready is high in the same cycle as done, so back-to-back requests are possible: start sampled in that cycle is accepted.
- Width: mag and the shifter are INT_W bits wide. Normal-class left shifts never lose the leading 1, because k<=INT_W-2.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined:
  - Right shifts track a guard bit and a sticky bit.
  - SIGN adds a round-to-nearest-even increment to mag before negation.
  - No extra cycles; latency is unchanged. Overflow cannot arise, because right shifts only occur for mag<256.
- Undefined: truncation toward zero, with no guard or sticky logic.

Test Plan:
- Reset, then a=0x3F80 (1.0) with start: done after 10 edges, result=0x0001, overflow=0. Also a=0x42C8 (100.0): done after 4 edges, result=0x0064.
- a=0xC380 (-256.0): one left shift, result=0xFF00, overflow=0. Also a=0xC700 (-32768): result=0x8000, overflow=0, latency 3.
- Range and special values:
  - a=0x471C (40000) gives 0x7FFF, overflow=1.
  - a=0x7F80 (+Inf) gives 0x7FFF, overflow=1.
  - a=0x7FC1 (NaN) gives 0x0000, overflow=1.
  - a=0x3F00 (0.5) gives 0x0000, overflow=0.
  - All special values take 3 edges.
- a=0x4060 (3.5) and 0x4020 (2.5): without macro, results 3 and 2. With ROUND_NEAREST_EN, results 4 and 2. With the macro, 0xC060 (-3.5) gives 0xFFFC.
- Handshake checks:
  - start pulsed while busy is ignored.
  - start held high through done: the next operand is accepted in the done cycle, and the second done follows with its own correct latency.
- Reset asserted mid-SHIFT: next cycle ready=1, done=0, result=0. No done pulse appears for the aborted operand.
